// File: rtl/xgmii_pkg.sv
// ----------------------------------------------------------------------------
// xgmii_pkg
// Shared XGMII character codes, the link status encoding, the per-column
// classification record and a lane unpack helper. Used by
// xgmii_col_decode and xgmii_rx_link_monitor.
// ----------------------------------------------------------------------------
package xgmii_pkg;

    localparam logic [7:0] XGMII_START  = 8'hFB;
    localparam logic [7:0] XGMII_TERM   = 8'hFD;
    localparam logic [7:0] XGMII_ERROR  = 8'hFE;
    localparam logic [7:0] XGMII_SEQ    = 8'h9C;
    localparam logic [7:0] XGMII_IDLE   = 8'h07;
    localparam logic [7:0] FAULT_LOCAL  = 8'h01;
    localparam logic [7:0] FAULT_REMOTE = 8'h02;

    typedef enum logic [1:0] {
        LINK_OK           = 2'd0,
        LINK_LOCAL_FAULT  = 2'd1,
        LINK_REMOTE_FAULT = 2'd2
    } link_status_t;

    typedef struct packed {
        logic       ctrl;
        logic [7:0] data;
    } xgmii_lane_t;

    // seq_type reuses the link status encoding: a local fault sequence
    // drives LINK_LOCAL_FAULT, a remote one LINK_REMOTE_FAULT.
    typedef struct packed {
        logic         is_seq;
        link_status_t seq_type;
        logic         start;
        logic         term;
        logic         err;
    } col_info_t;

    // Lane idx (0..3) of a 4-lane column: data [9i+7:9i], ctrl [9i+8].
    function automatic xgmii_lane_t lane_unpack(input logic [35:0] col,
                                                input logic [1:0]  idx);
        return xgmii_lane_t'(col[int'(idx) * 9 +: 9]);
    endfunction

endpackage

// File: rtl/xgmii_col_decode.sv
// ----------------------------------------------------------------------------
// xgmii_col_decode
// Classifies one 4-lane XGMII column.
//   col   in   36  lanes 0..3 of the column, 9 bits each {ctrl, data}
//   info  out  col_info_t
//         is_seq/seq_type : column is a local or remote fault sequence set
//         start           : Start control character in lane 0 of the column
//         term            : Terminate control character in any lane
//         err             : Error control character in any lane
// ----------------------------------------------------------------------------
module xgmii_col_decode
    import xgmii_pkg::*;
(
    input  logic [35:0] col,
    output col_info_t   info
);

    xgmii_lane_t l0, l1, l2, l3, ln;

    always_comb begin
        l0   = lane_unpack(col, 2'd0);
        l1   = lane_unpack(col, 2'd1);
        l2   = lane_unpack(col, 2'd2);
        l3   = lane_unpack(col, 2'd3);
        ln   = '0;
        info = '0;

        if (l0.ctrl && (l0.data == XGMII_SEQ) &&
            !l1.ctrl && !l2.ctrl && !l3.ctrl &&
            (l1.data == 8'h00) && (l2.data == 8'h00)) begin
            if (l3.data == FAULT_LOCAL) begin
                info.is_seq   = 1'b1;
                info.seq_type = LINK_LOCAL_FAULT;
            end else if (l3.data == FAULT_REMOTE) begin
                info.is_seq   = 1'b1;
                info.seq_type = LINK_REMOTE_FAULT;
            end
        end

        // Start is only legal in the first lane of a column.
        info.start = l0.ctrl && (l0.data == XGMII_START);

        for (int i = 0; i < 4; i++) begin
            ln = lane_unpack(col, 2'(i));
            if (ln.ctrl && (ln.data == XGMII_TERM))  info.term = 1'b1;
            if (ln.ctrl && (ln.data == XGMII_ERROR)) info.err  = 1'b1;
        end
    end

endmodule

// File: rtl/xgmii_rx_link_monitor.sv
// ----------------------------------------------------------------------------
// xgmii_rx_link_monitor
// RS link-fault monitor on the XGMII receive path of one 10GBASE-R port,
// with optional good/errored frame statistics.
//
// Ports
//   clk_156mhz     in   1      XGMII receive clock
//   rst_156mhz     in   1      synchronous active-high reset
//   xgmii_rx_dc    in   72     lanes 0-3 = column 0, lanes 4-7 = column 1
//   link_status    out  2      0 OK, 1 local fault, 2 remote fault
//   link_up        out  1      OK held for a full fault-free window
//   fault_evt      out  1      one-cycle pulse on every link_status change
//   stats_clear    in   1      clear both statistics counters
//   rx_frames      out  CNT_W  good frames (saturating)
//   rx_err_frames  out  CNT_W  errored / unterminated frames (saturating)
//
// Build option: define XGMII_RX_MON_STATS_EN to build the frame tracker and
// counters; without it the counters read 0 and stats_clear is ignored.
//
// Link states
//   state              | meaning
//   LINK_OK            | no fault condition
//   LINK_LOCAL_FAULT   | FAULT_THRESH local fault sets inside the window
//   LINK_REMOTE_FAULT  | FAULT_THRESH remote fault sets inside the window
// ----------------------------------------------------------------------------
module xgmii_rx_link_monitor
    import xgmii_pkg::*;
#(
    parameter int unsigned FAULT_THRESH = 4,
    parameter int unsigned WINDOW_COLS  = 128,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk_156mhz,
    input  logic             rst_156mhz,
    input  logic [71:0]      xgmii_rx_dc,
    output logic [1:0]       link_status,
    output logic             link_up,
    output logic             fault_evt,
    input  logic             stats_clear,
    output logic [CNT_W-1:0] rx_frames,
    output logic [CNT_W-1:0] rx_err_frames
);

    localparam int unsigned SEQ_W = $clog2(FAULT_THRESH + 1);
    localparam int unsigned COL_W = $clog2(WINDOW_COLS + 1);
    localparam logic [SEQ_W-1:0] THR = SEQ_W'(FAULT_THRESH);
    localparam logic [COL_W-1:0] WIN = COL_W'(WINDOW_COLS);

    col_info_t info [2];

    xgmii_col_decode u_col0 (.col(xgmii_rx_dc[35:0]),  .info(info[0]));
    xgmii_col_decode u_col1 (.col(xgmii_rx_dc[71:36]), .info(info[1]));

    link_status_t     state, state_n;
    link_status_t     last_type, last_type_n;
    logic [SEQ_W-1:0] seq_cnt, seq_cnt_n;
    logic [COL_W-1:0] col_cnt, col_cnt_n;
    logic [COL_W-1:0] up_cnt, up_cnt_n;
    logic             link_up_n;

    always_ff @(posedge clk_156mhz) begin
        if (rst_156mhz) begin
            state     <= LINK_OK;
            last_type <= LINK_OK;
            seq_cnt   <= '0;
            col_cnt   <= '0;
            up_cnt    <= '0;
            link_up   <= 1'b0;
            fault_evt <= 1'b0;
        end else begin
            state     <= state_n;
            last_type <= last_type_n;
            seq_cnt   <= seq_cnt_n;
            col_cnt   <= col_cnt_n;
            up_cnt    <= up_cnt_n;
            link_up   <= link_up_n;
            fault_evt <= (state_n != state);
        end
    end

    // Column 0 is folded in before column 1 so a word holding both fault
    // types leaves the column-1 type as the one being counted. last_type of
    // LINK_OK means no sequence seen yet, so the first one always restarts.
    // col_cnt restarts on every fault set so that returning to OK needs a
    // full window of consecutive fault-free columns.
    always_comb begin
        state_n     = state;
        last_type_n = last_type;
        seq_cnt_n   = seq_cnt;
        col_cnt_n   = col_cnt;
        up_cnt_n    = up_cnt;

        for (int c = 0; c < 2; c++) begin
            if (info[c].is_seq) begin
                if ((info[c].seq_type != last_type_n) || (col_cnt_n >= WIN)) begin
                    seq_cnt_n   = SEQ_W'(1);
                    last_type_n = info[c].seq_type;
                end else if (seq_cnt_n != THR) begin
                    seq_cnt_n = seq_cnt_n + 1'b1;
                end
                col_cnt_n = '0;
                if (seq_cnt_n == THR) state_n = info[c].seq_type;
            end else begin
                if (col_cnt_n != WIN) col_cnt_n = col_cnt_n + 1'b1;
                if ((state_n != LINK_OK) && (col_cnt_n == WIN)) state_n = LINK_OK;
            end

            if ((state_n != LINK_OK) || info[c].is_seq) begin
                up_cnt_n = '0;
            end else if (up_cnt_n != WIN) begin
                up_cnt_n = up_cnt_n + 1'b1;
            end
        end

        // Once earned, link_up holds until the status leaves OK.
        link_up_n = (state_n == LINK_OK) && (link_up || (up_cnt_n == WIN));
    end

    assign link_status = state;

`ifdef XGMII_RX_MON_STATS_EN

    logic       in_frame, in_frame_n;
    logic       bad, bad_n;
    logic [1:0] add_good, add_err;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Within a column the Start (lane 0) comes first, then any Error or
    // Terminate in the later lanes. Two columns can each close a frame, so
    // a counter may advance by two in one word.
    always_comb begin
        in_frame_n = in_frame;
        bad_n      = bad;
        add_good   = 2'd0;
        add_err    = 2'd0;

        for (int c = 0; c < 2; c++) begin
            if (info[c].start) begin
                if (in_frame_n) add_err = add_err + 2'd1;
                in_frame_n = 1'b1;
                bad_n      = 1'b0;
            end
            if (info[c].err && in_frame_n) bad_n = 1'b1;
            if (info[c].term && in_frame_n) begin
                if (bad_n) add_err  = add_err + 2'd1;
                else       add_good = add_good + 2'd1;
                in_frame_n = 1'b0;
                bad_n      = 1'b0;
            end
            if (info[c].is_seq && in_frame_n) begin
                add_err    = add_err + 2'd1;
                in_frame_n = 1'b0;
                bad_n      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_156mhz) begin
        if (rst_156mhz) begin
            in_frame      <= 1'b0;
            bad           <= 1'b0;
            rx_frames     <= '0;
            rx_err_frames <= '0;
        end else begin
            in_frame <= in_frame_n;
            bad      <= bad_n;
            if (stats_clear) begin
                rx_frames     <= '0;
                rx_err_frames <= '0;
            end else begin
                rx_frames     <= sat_add(rx_frames, add_good);
                rx_err_frames <= sat_add(rx_err_frames, add_err);
            end
        end
    end

`else

    assign rx_frames     = '0;
    assign rx_err_frames = '0;

    logic unused_stats;
    assign unused_stats = ^{stats_clear,
                            info[0].start, info[0].term, info[0].err,
                            info[1].start, info[1].term, info[1].err};

`endif

endmodule

// File: tb/tb_xgmii_rx_link_monitor.sv
module tb_xgmii_rx_link_monitor;

    localparam int CNT_W = 4;

    localparam logic [35:0] COL_IDLE  = {9'h107, 9'h107, 9'h107, 9'h107};
    localparam logic [35:0] COL_DATA  = {9'h044, 9'h033, 9'h022, 9'h011};
    localparam logic [35:0] COL_DERR  = {9'h044, 9'h033, 9'h1FE, 9'h011};
    localparam logic [35:0] COL_START = {9'h055, 9'h055, 9'h055, 9'h1FB};
    localparam logic [35:0] COL_TERM  = {9'h107, 9'h107, 9'h107, 9'h1FD};

    localparam logic [71:0] W_IDLE  = {COL_IDLE, COL_IDLE};
    localparam logic [71:0] W_START = {COL_DATA, COL_START};
    localparam logic [71:0] W_BAD   = {COL_DERR, COL_START};
    localparam logic [71:0] W_TERM  = {COL_IDLE, COL_TERM};
    localparam logic [71:0] W_TS    = {COL_START, COL_TERM};

    // check mask bits: 0 status, 1 link_up, 2 fault_evt, 3 counters
    localparam logic [3:0] M_ALL = 4'hF;
    localparam logic [3:0] M_LNK = 4'hD;

    logic             clk_156mhz = 1'b0;
    logic             rst_156mhz = 1'b1;
    logic [71:0]      xgmii_rx_dc = W_IDLE;
    logic             stats_clear = 1'b0;
    logic [1:0]       link_status;
    logic             link_up;
    logic             fault_evt;
    logic [CNT_W-1:0] rx_frames;
    logic [CNT_W-1:0] rx_err_frames;

    logic drv_valid = 1'b0;

    always #5 clk_156mhz = ~clk_156mhz;

    xgmii_rx_link_monitor #(
        .FAULT_THRESH (4),
        .WINDOW_COLS  (128),
        .CNT_W        (CNT_W)
    ) dut (
        .clk_156mhz    (clk_156mhz),
        .rst_156mhz    (rst_156mhz),
        .xgmii_rx_dc   (xgmii_rx_dc),
        .link_status   (link_status),
        .link_up       (link_up),
        .fault_evt     (fault_evt),
        .stats_clear   (stats_clear),
        .rx_frames     (rx_frames),
        .rx_err_frames (rx_err_frames)
    );

    typedef struct {
        logic [3:0]       mask;
        logic [1:0]       st;
        logic             up;
        logic             evt;
        logic [CNT_W-1:0] fr;
        logic [CNT_W-1:0] er;
        int               tag;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   word_no    = 0;
    int   ef         = 0;
    int   ee         = 0;

    function automatic logic [CNT_W-1:0] sat(input int v);
        int mx;
        mx = (1 << CNT_W) - 1;
        return (v > mx) ? CNT_W'(mx) : CNT_W'(v);
    endfunction

    function automatic logic [35:0] col_seq(input logic [7:0] t);
        return {1'b0, t, 9'h000, 9'h000, 9'h19C};
    endfunction

    function automatic logic [71:0] wseq(input logic [7:0] t1, input logic [7:0] t0);
        return {col_seq(t1), col_seq(t0)};
    endfunction

    task automatic cmp(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s word %0d: got %0h expected %0h", nm, tag, act, exp);
        end
    endtask

    task automatic drive(input logic [71:0] w, input logic r, input logic clr,
                         input logic [3:0] m, input logic [1:0] st,
                         input logic up, input logic evt);
        exp_t e;
        @(negedge clk_156mhz);
        xgmii_rx_dc = w;
        rst_156mhz  = r;
        stats_clear = clr;
        drv_valid   = 1'b1;
        word_no++;
        e.mask = m;
        e.st   = st;
        e.up   = up;
        e.evt  = evt;
        e.fr   = sat(ef);
        e.er   = sat(ee);
        e.tag  = word_no;
        sb.push_back(e);
    endtask

    task automatic frame_done(input bit bad);
`ifdef XGMII_RX_MON_STATS_EN
        if (bad) ee++;
        else     ef++;
`endif
    endtask

    task automatic start_err();
`ifdef XGMII_RX_MON_STATS_EN
        ee++;
`endif
    endtask

    task automatic frame(input bit bad);
        drive(bad ? W_BAD : W_START, 1'b0, 1'b0, M_LNK, 2'd0, 1'b0, 1'b0);
        frame_done(bad);
        drive(W_TERM, 1'b0, 1'b0, M_LNK, 2'd0, 1'b0, 1'b0);
    endtask

    // Monitor: a word captured on a posedge has its result checked on the
    // following negedge against the oldest queued expectation.
    initial begin
        logic pend;
        exp_t e;
        forever begin
            @(posedge clk_156mhz);
            pend = drv_valid;
            @(negedge clk_156mhz);
            if (pend) begin
                if (sb.size() == 0) begin
                    cmp("scoreboard_empty", word_no, 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    if (e.mask[0]) cmp("link_status", e.tag, 32'(link_status), 32'(e.st));
                    if (e.mask[1]) cmp("link_up", e.tag, 32'(link_up), 32'(e.up));
                    if (e.mask[2]) cmp("fault_evt", e.tag, 32'(fault_evt), 32'(e.evt));
                    if (e.mask[3]) begin
                        cmp("rx_frames", e.tag, 32'(rx_frames), 32'(e.fr));
                        cmp("rx_err_frames", e.tag, 32'(rx_err_frames), 32'(e.er));
                    end
                end
            end
        end
    end

    initial begin
        // reset
        repeat (2) drive(W_IDLE, 1'b1, 1'b0, M_ALL, 2'd0, 1'b0, 1'b0);

        // idle: link_up after 64 words (128 fault-free columns)
        for (int i = 1; i <= 64; i++)
            drive(W_IDLE, 1'b0, 1'b0, M_ALL, 2'd0, (i == 64), 1'b0);

        // local fault: 4 sets over 2 words
        drive(wseq(8'h01, 8'h01), 1'b0, 1'b0, M_ALL, 2'd0, 1'b1, 1'b0);
        drive(wseq(8'h01, 8'h01), 1'b0, 1'b0, M_ALL, 2'd1, 1'b0, 1'b1);

        // 126 clean columns is not enough to recover
        for (int i = 1; i <= 63; i++)
            drive(W_IDLE, 1'b0, 1'b0, M_ALL, 2'd1, 1'b0, 1'b0);

        // remote fault replaces local fault
        drive(wseq(8'h02, 8'h02), 1'b0, 1'b0, M_ALL, 2'd1, 1'b0, 1'b0);
        drive(wseq(8'h02, 8'h02), 1'b0, 1'b0, M_ALL, 2'd2, 1'b0, 1'b1);

        // 128 clean columns -> OK
        for (int i = 1; i <= 64; i++)
            drive(W_IDLE, 1'b0, 1'b0, M_ALL, (i == 64) ? 2'd0 : 2'd2, 1'b0, (i == 64));

        // mixed types restart the count; col1 (remote) is the one kept
        drive(wseq(8'h02, 8'h01), 1'b0, 1'b0, M_ALL, 2'd0, 1'b0, 1'b0);
        drive(wseq(8'h02, 8'h01), 1'b0, 1'b0, M_ALL, 2'd0, 1'b0, 1'b0);
        drive(wseq(8'h02, 8'h02), 1'b0, 1'b0, M_ALL, 2'd0, 1'b0, 1'b0);
        drive(wseq(8'h02, 8'h02), 1'b0, 1'b0, M_ALL, 2'd2, 1'b0, 1'b1);
        for (int i = 1; i <= 64; i++)
            drive(W_IDLE, 1'b0, 1'b0, M_ALL, (i == 64) ? 2'd0 : 2'd2, 1'b0, (i == 64));

        // lane3 = 0x03 is not a fault sequence
        repeat (4) drive(wseq(8'h03, 8'h03), 1'b0, 1'b0, M_LNK, 2'd0, 1'b0, 1'b0);

        // 10 frames, frame 3 carries an Error in lane 5
        for (int f = 1; f <= 10; f++) frame(f == 3);

        // Terminate in column 0 and Start in lane 4 of the same word
        drive(W_START, 1'b0, 1'b0, M_LNK, 2'd0, 1'b0, 1'b0);
        frame_done(1'b0);
        drive(W_TS, 1'b0, 1'b0, M_LNK, 2'd0, 1'b0, 1'b0);
        frame_done(1'b0);
        drive(W_TERM, 1'b0, 1'b0, M_LNK, 2'd0, 1'b0, 1'b0);

        // Start while in a frame
        drive(W_START, 1'b0, 1'b0, M_LNK, 2'd0, 1'b0, 1'b0);
        start_err();
        drive(W_START, 1'b0, 1'b0, M_LNK, 2'd0, 1'b0, 1'b0);
        frame_done(1'b0);
        drive(W_TERM, 1'b0, 1'b0, M_LNK, 2'd0, 1'b0, 1'b0);

        // fault sequence inside a frame aborts it
        drive(W_START, 1'b0, 1'b0, M_LNK, 2'd0, 1'b0, 1'b0);
        start_err();
        drive(wseq(8'h01, 8'h01), 1'b0, 1'b0, M_LNK, 2'd0, 1'b0, 1'b0);
        drive(W_IDLE, 1'b0, 1'b0, M_LNK, 2'd0, 1'b0, 1'b0);

        // saturation at all-ones
        for (int f = 1; f <= 5; f++) frame(1'b0);

        // clear beats a same-cycle increment
        drive(W_START, 1'b0, 1'b0, M_LNK, 2'd0, 1'b0, 1'b0);
        ef = 0;
        ee = 0;
        drive(W_TERM, 1'b0, 1'b1, M_LNK, 2'd0, 1'b0, 1'b0);
        frame(1'b0);

        @(negedge clk_156mhz);
        drv_valid   = 1'b0;
        stats_clear = 1'b0;
        xgmii_rx_dc = W_IDLE;
        repeat (3) @(negedge clk_156mhz);
        cmp("scoreboard_drained", word_no, 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
